// File: rtl/motor_cmd_uart_tx.sv
// Turns single-cycle motor command pulses into 5-byte Drive packets (opcode 0x89) on an 8N1 UART line.
// Define MOTOR_TX_INIT_EN to send the Start (0x80) and Safe (0x83) bytes after every reset.
module motor_cmd_uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FWD_SPEED    = 200,
    parameter int TURN_SPEED   = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       forward_rst,
    input  logic       reverse_rst,
    input  logic       stop_rst,
    input  logic       turn_rst,
    input  logic       tb_rst,
    output logic       uart_tx,
    output logic       busy,
    output logic [2:0] last_cmd
);

`ifdef MOTOR_TX_INIT_EN
    localparam logic INIT_EN = 1'b1;
`else
    localparam logic INIT_EN = 1'b0;
`endif

    localparam logic [2:0]  CMD_NONE = 3'd0;
    localparam logic [2:0]  CMD_FWD  = 3'd1;
    localparam logic [2:0]  CMD_REV  = 3'd2;
    localparam logic [2:0]  CMD_STOP = 3'd3;
    localparam logic [2:0]  CMD_CCW  = 3'd4;
    localparam logic [2:0]  CMD_CW   = 3'd5;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] FWD_VEL  = 16'(FWD_SPEED);
    localparam logic [15:0] REV_VEL  = ~FWD_VEL + 16'd1;
    localparam logic [15:0] TURN_VEL = 16'(TURN_SPEED);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

    function automatic logic [2:0] pick_cmd(input logic fwd, input logic rev, input logic stp,
                                            input logic ccw, input logic cw);
        if (stp)      return CMD_STOP;
        else if (rev) return CMD_REV;
        else if (fwd) return CMD_FWD;
        else if (ccw) return CMD_CCW;
        else if (cw)  return CMD_CW;
        else          return CMD_NONE;
    endfunction

    // CMD_NONE selects the two init bytes; the trailing bytes are never sent for it.
    function automatic logic [39:0] build_packet(input logic [2:0] cmd);
        case (cmd)
            CMD_FWD:  return {8'h89, FWD_VEL,  16'h8000};
            CMD_REV:  return {8'h89, REV_VEL,  16'h8000};
            CMD_STOP: return {8'h89, 16'h0000, 16'h8000};
            CMD_CCW:  return {8'h89, TURN_VEL, 16'h0001};
            CMD_CW:   return {8'h89, TURN_VEL, 16'hFFFF};
            default:  return {8'h80, 8'h83, 24'h000000};
        endcase
    endfunction

    function automatic logic [7:0] byte_at(input logic [39:0] pkt, input logic [2:0] idx);
        case (idx)
            3'd0:    return pkt[39:32];
            3'd1:    return pkt[31:24];
            3'd2:    return pkt[23:16];
            3'd3:    return pkt[15:8];
            3'd4:    return pkt[7:0];
            default: return 8'hFF;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  byte_q, byte_d;
    logic [2:0]  last_byte_q, last_byte_d;
    logic [39:0] pkt_q, pkt_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [2:0]  pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic        init_q, init_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic [2:0]  last_cmd_q, last_cmd_d;
    logic [2:0]  win_s;
    logic        stash_s;
    logic [7:0]  cur_byte_s;

    // Next-state, pending-slot and output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        last_byte_d = last_byte_q;
        pkt_d       = pkt_q;
        cmd_d       = cmd_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        init_d      = init_q;
        last_cmd_d  = last_cmd_q;
        win_s       = pick_cmd(forward_rst, reverse_rst, stop_rst, turn_rst, tb_rst);
        stash_s     = (win_s != CMD_NONE) && ((state_q != S_IDLE) || init_q);

        case (state_q)
            S_IDLE: begin
                if (init_q) begin
                    init_d  = 1'b0;
                    cmd_d   = CMD_NONE;
                    state_d = S_LOAD;
                end else if (win_s != CMD_NONE) begin
                    cmd_d      = win_s;
                    last_cmd_d = win_s;
                    pend_v_d   = 1'b0;
                    state_d    = S_LOAD;
                end else if (pend_v_q) begin
                    cmd_d      = pend_q;
                    last_cmd_d = pend_q;
                    pend_v_d   = 1'b0;
                    state_d    = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                pkt_d       = build_packet(cmd_q);
                last_byte_d = (cmd_q == CMD_NONE) ? 3'd1 : 3'd4;
                byte_d      = 3'd0;
                bit_d       = 3'd0;
                cnt_d       = 16'd0;
                state_d     = S_START;
            end
            S_START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = 16'd0;
                    if (byte_q < last_byte_q) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = S_START;
                    end else if (pend_v_q) begin
                        cmd_d      = pend_q;
                        last_cmd_d = pend_q;
                        pend_v_d   = 1'b0;
                        state_d    = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A pulse that cannot start now lands in the slot, overriding anything consumed above.
        pend_v_d = pend_v_d | stash_s;
        pend_d   = stash_s ? win_s : pend_d;

        cur_byte_s = byte_at(pkt_d, byte_d);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = cur_byte_s[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE) || pend_v_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 16'd0;
            bit_q       <= 3'd0;
            byte_q      <= 3'd0;
            last_byte_q <= 3'd0;
            pkt_q       <= 40'd0;
            cmd_q       <= CMD_NONE;
            pend_q      <= CMD_NONE;
            pend_v_q    <= 1'b0;
            init_q      <= INIT_EN;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            last_cmd_q  <= CMD_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            last_byte_q <= last_byte_d;
            pkt_q       <= pkt_d;
            cmd_q       <= cmd_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            init_q      <= init_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            last_cmd_q  <= last_cmd_d;
        end
    end

    assign uart_tx  = tx_q;
    assign busy     = busy_q;
    assign last_cmd = last_cmd_q;

endmodule
